// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART transmit buffer between two frame sources.
// It loads the winning frame byte by byte, then holds the UART until that frame has been sent.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NBYTES  = 4,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [8*NBYTES-1:0]   req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [8*NBYTES-1:0]   req1_data,
    output logic                  req1_ready,
    output logic [ADDR_W-1:0]     uart_address,
    output logic [7:0]            uart_w_data,
    output logic                  uart_we,
    input  logic                  uart_tx_busy,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  clr_err
);
    localparam int CW = $clog2(NBYTES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_START, WAIT_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [NBYTES-1:0][7:0]  frame_q, frame_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic                    sel, accept, set_err;

    // sel=1 picks requester 1; on contention the one that did not go last wins.
    // Ready is masked by rst_n so every output reads 0 while reset is held.
    always_comb begin
        sel    = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
        accept = rst_n && (state_q == IDLE) && !uart_tx_busy && (req0_valid || req1_valid);
    end

    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        frame_d = frame_q;
        grant_d = grant_q;
        last_d  = last_q;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d = sel ? req1_data : req0_data;
                    grant_d = sel ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == CW'(NBYTES - 1)) begin
                    tcnt_d  = '0;
                    state_d = WAIT_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_START: begin
                // A busy rise on the final count still wins over the timeout.
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    last_d  = grant_q[1];
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    last_d  = grant_q[1];
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = set_err | (err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            frame_q <= '0;
            grant_q <= '0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            frame_q <= frame_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign uart_we      = (state_q == WRITE);
    assign uart_address = uart_we ? ADDR_W'(cnt_q) : '0;
    assign uart_w_data  = uart_we ? frame_q[cnt_q[IW-1:0]] : '0;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios pinned with literal values, then random traffic
// checked every cycle against a frame-level timing model with a simple UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic [2:0]  uart_address;
    logic [7:0]  uart_w_data;
    logic        uart_we;
    logic        uart_tx_busy = 1'b0;
    logic [1:0]  grant;
    logic        busy, timeout_err;
    logic        clr_err = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NBYTES(N), .ADDR_W(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_address(uart_address), .uart_w_data(uart_w_data), .uart_we(uart_we),
        .uart_tx_busy(uart_tx_busy), .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    int checks = 0, failures = 0;

    // Stimulus variables
    bit          v0, v1, clr, ub, rnd;
    logic [31:0] d0, d1;
    int          fixed_delay, fixed_hold, start_cnt, hold_cnt, pend_hold;
    int          pick [8] = '{1, 2, 3, 5, 63, 64, 65, 0};
    bit          acc0, acc1;

    // Model: owner -1 when idle; m_t counts cycles since acceptance (1..N are write cycles)
    int          m_own, m_t, m_wait, m_last;
    bit          m_seen, m_err;
    logic [31:0] m_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        uart_tx_busy = ub; clr_err = clr;
    endtask

    task automatic mreset();
        m_own = -1; m_last = 1; m_err = 0; m_t = 0; m_wait = 0; m_seen = 0;
        start_cnt = 0; hold_cnt = 0; acc0 = 0; acc1 = 0;
    endtask

    task automatic release_reset();
        v0 = 0; v1 = 0; clr = 0; ub = 0;
        drive();
        rst_n = 1'b1;
        mreset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic cycle();
        bit idle, er0, er1, ewe, set;
        int w;
        @(negedge clk);
        // UART: busy starts start_cnt cycles after the last write and lasts pend_hold cycles
        if (start_cnt > 0) begin
            start_cnt--;
            if (start_cnt == 0) hold_cnt = pend_hold;
        end else if (rnd && m_own < 0 && hold_cnt == 0 && $urandom_range(19) == 0) begin
            hold_cnt = $urandom_range(4, 1);
        end
        ub = (hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt--;
        if (rnd) begin
            if (!v0 || acc0) begin v0 = $urandom_range(2) != 0; d0 = $urandom; end
            else if ($urandom_range(3) == 0) d0 = $urandom;
            if (!v1 || acc1) begin v1 = $urandom_range(2) != 0; d1 = $urandom; end
            else if ($urandom_range(3) == 0) d1 = $urandom;
            clr = ($urandom_range(29) == 0);
        end
        drive();
        #1;
        idle = (m_own < 0);
        w    = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
        er0  = idle && !ub && v0 && (w == 0);
        er1  = idle && !ub && v1 && (w == 1);
        ewe  = !idle && m_t >= 1 && m_t <= N;
        chk("ready0", req0_ready, er0);
        chk("ready1", req1_ready, er1);
        chk("we", uart_we, ewe);
        chk("grant", grant, idle ? 0 : (m_own == 0 ? 1 : 2));
        chk("busy", busy, !idle);
        chk("timeout_err", timeout_err, m_err);
        if (ewe) begin
            chk("address", uart_address, m_t - 1);
            chk("w_data", uart_w_data, m_frame[8*(m_t-1) +: 8]);
        end
        acc0 = er0; acc1 = er1;
        if (ewe && m_t == N) begin
            if (fixed_delay >= 0) begin start_cnt = fixed_delay; pend_hold = fixed_hold; end
            else begin start_cnt = pick[$urandom_range(7)]; pend_hold = $urandom_range(8, 1); end
        end
        set = 0;
        if (idle) begin
            if (er0 || er1) begin
                m_own = er0 ? 0 : 1; m_frame = er0 ? d0 : d1;
                m_t = 1; m_wait = 0; m_seen = 0;
            end
        end else if (m_t <= N) begin
            m_t++;
        end else if (!m_seen) begin
            if (ub) m_seen = 1;
            else if (m_wait == TO - 1) begin set = 1; m_last = m_own; m_own = -1; end
            else m_wait++;
        end else if (!ub) begin
            m_last = m_own; m_own = -1;
        end
        m_err = set || (m_err && !clr);
    endtask

    initial begin
        int order [4];
        int n, j;
        logic [7:0] exp_b [4];
        rnd = 0; fixed_delay = 2; fixed_hold = 100;
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; clr = 0; ub = 0;
        mreset();

        // Reset state: outputs 0 even with both requesters valid
        @(negedge clk);
        v0 = 1; v1 = 1; drive();
        #1;
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_we", uart_we, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        @(negedge clk);
        release_reset();

        // Single request 44332211, UART busy 2 cycles after last write for 100 cycles
        v0 = 1; d0 = 32'h44332211;
        cycle();
        chk("t1_ready0", req0_ready, 1);
        v0 = 0;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t1_we", uart_we, 1);
            chk("t1_addr", uart_address, i);
            chk("t1_data", uart_w_data, exp_b[i]);
            chk("t1_grant", grant, 2'b01);
        end
        for (int k = 6; k <= 108; k++) begin
            cycle();
            if (k == 107) chk("t2_still_busy", busy, 1);
            if (k == 108) begin
                chk("t2_idle", busy, 0);
                chk("t2_grant", grant, 0);
            end
        end

        // Contention from reset: A, B, A, B
        do_reset();
        fixed_delay = 2; fixed_hold = 3;
        v0 = 1; v1 = 1; d0 = 32'hA0A1A2A3; d1 = 32'hB0B1B2B3;
        n = 0;
        for (int k = 0; k < 400 && n < 4; k++) begin
            cycle();
            if (acc0 || acc1) begin order[n] = acc1 ? 1 : 0; n++; end
        end
        if (n < 4) chk("t3_grants_seen", n, 4);
        else for (int i = 0; i < 4; i++) chk("t3_order", order[i], i % 2);

        // Timeout: UART never goes busy
        do_reset();
        fixed_delay = 0; v1 = 0; v0 = 1; d0 = $urandom;
        cycle();
        chk("t4_ready0", req0_ready, 1);
        v0 = 0;
        repeat (4) cycle();
        for (j = 1; j <= 65; j++) begin
            cycle();
            if (j == 64) chk("t4_err_early", timeout_err, 0);
            if (j == 65) begin
                chk("t4_err", timeout_err, 1);
                chk("t4_idle", busy, 0);
            end
        end
        clr = 1; cycle(); clr = 0; cycle();
        chk("t4_clr", timeout_err, 0);
        // Busy rising on the last allowed count gives no error
        fixed_delay = 64; fixed_hold = 3; v0 = 1;
        cycle();
        chk("t4b_ready0", req0_ready, 1);
        v0 = 0;
        repeat (74) cycle();
        chk("t4b_no_err", timeout_err, 0);
        chk("t4b_idle", busy, 0);

        // Reset in the middle of a frame
        do_reset();
        fixed_delay = 2; fixed_hold = 3;
        v0 = 1; v1 = 1; d0 = 32'hDEADBEEF; d1 = 32'h01234567;
        repeat (3) cycle();
        chk("t5_byte1", uart_address, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_we", uart_we, 0);
        chk("t5_grant", grant, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", {req0_ready, req1_ready}, 0);
        chk("t5_data", {uart_address, uart_w_data}, 0);
        repeat (2) @(negedge clk);
        release_reset();
        v0 = 1; v1 = 1;
        cycle();
        chk("t5_first", {req1_ready, req0_ready}, 2'b01);

        // UART busy while idle with both requesters waiting
        do_reset();
        v0 = 1; v1 = 1; hold_cnt = 5;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t6_no_ready", {req1_ready, req0_ready}, 0);
        end
        cycle();
        chk("t6_ready0", {req1_ready, req0_ready}, 2'b01);
        cycle();
        chk("t6_grant", grant, 2'b01);

        // Random traffic
        do_reset();
        rnd = 1; fixed_delay = -1;
        repeat (3000) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the UART transmit path between two independent requesters, each offering one NBYTES-byte frame per handshake. A round-robin arbiter picks the winner and loads the frame byte by byte into the UART transmit buffer through its address/w_data/we write port. It then waits until the UART has started and finished sending the frame before it grants again. It sits between the CPU/peripheral sources and the UART block.

Parameters:
NBYTES, 4, bytes per frame; equals the UART transmit buffer depth.
ADDR_W, 3, width of the UART buffer address bus.
TIMEOUT, 64, cycles allowed for uart_tx_busy to rise after the last byte is written.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req0_valid  in  1  requester 0 has a frame.
req0_data  in  8*NBYTES  requester 0 frame; byte i = bits [8i+7:8i].
req0_ready  out  1  requester 0 frame accepted this cycle.
req1_valid  in  1  requester 1 has a frame.
req1_data  in  8*NBYTES  requester 1 frame.
req1_ready  out  1  requester 1 frame accepted this cycle.
uart_address  out  ADDR_W  UART buffer byte address.
uart_w_data  out  8  byte written to the UART.
uart_we  out  1  UART write strobe.
uart_tx_busy  in  1  high while the UART transmit buffer holds or is sending a frame.
grant  out  2  one-hot owner of the current frame; 00 when idle.
busy  out  1  high in any state other than IDLE.
timeout_err  out  1  sticky; set when uart_tx_busy fails to rise.
clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 immediately, including uart_we, grant, busy and timeout_err.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
  - Reset mid-write abandons the frame; no further writes are issued.
- FSM states: IDLE, WRITE, WAIT_START, WAIT_DONE.
- IDLE:
  - Ready is combinational: reqN_ready=1 for the selected requester only, when state=IDLE, uart_tx_busy=0 and reqN_valid=1.
  - Selection: if only one requester is valid, it wins. If both are valid, the requester other than last wins.
  - On the accepting edge, the arbiter latches the frame, sets grant to one-hot of the winner, clears the byte counter, and moves to WRITE.
  - If uart_tx_busy=1 in IDLE (another writer is active), no ready is given.
- WRITE:
  - Runs for NBYTES consecutive cycles with uart_we=1, uart_address=cnt and uart_w_data=latched byte cnt, for cnt=0..NBYTES-1.
  - After cnt=NBYTES-1, go to WAIT_START and load the timeout counter with 0.
  - Latency: the first write is the cycle after acceptance; the last write is NBYTES cycles after acceptance.
- WAIT_START:
  - If uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without busy, set timeout_err=1, go to IDLE, and update last to the granted requester.
  - Busy in the same cycle as the timeout count takes priority: go to WAIT_DONE, no error.
- WAIT_DONE:
  - Wait for uart_tx_busy=0. No timeout here, because frame time depends on the baud rate.
  - On busy=0, go to IDLE, set last to the granted requester, and set grant=00.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- A newly valid requester waits at most one frame.
- Valid without ready: the requester holds valid and data stable. Changing data while waiting is allowed; the arbiter samples only on the accepting edge.
- Error register: clr_err=1 clears timeout_err on the next edge. If a set and a clear occur in the same cycle, the set wins.
- The byte counter is sized $clog2(NBYTES)+1, and the timeout counter $clog2(TIMEOUT)+1; neither wraps.
- uart_address upper bits are zero-extended.

Test Plan:
1. Reset then single request: req0_valid=1, req0_data=32'h44332211, uart_tx_busy=0.
   -> req0_ready pulses 1 cycle.
   -> Next 4 cycles: we=1, address 0..3, data 11,22,33,44.
   -> grant=01 and busy=1 throughout the frame.
2. UART model drives busy 2 cycles after the last write and holds it 100 cycles.
   -> FSM stays in WAIT_DONE.
   -> Returns to IDLE one edge after busy falls; grant=00.
3. Contention: both valid from reset with frames A/B.
   -> Order A, B, A, B.
   -> No ready is given while busy=1.
   -> No uart_we occurs outside WRITE.
4. Timeout: never assert uart_tx_busy.
   -> timeout_err=1 exactly 64 cycles after entering WAIT_START; FSM returns to IDLE.
   -> clr_err clears the flag.
   -> Busy rising on cycle 63 gives no error.
5. Reset mid-WRITE: assert rst_n=0 after byte 1 is written.
   -> uart_we drops asynchronously; all outputs return to 0.
   -> After release, requester 0 is served first.
6. uart_tx_busy=1 while in IDLE with both requesters valid.
   -> Both ready signals stay 0.
   -> The grant occurs on the first cycle after busy falls.
